// File: rtl/cordic_tanh_divider.sv
// tanh = sinh/cosh from one registered CORDIC pair, using a restoring divider
// that resolves one quotient bit per clock; saturates to +/-(2^(LEN-1)-1).
module cordic_tanh_divider #(
  parameter int LEN      = 16,
  parameter int OUT_FRAC = LEN - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [LEN-1:0] sinh,
  input  logic        [LEN-1:0] cosh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [LEN-1:0] tanh,
  output logic                  sat
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(LEN + 1);
  localparam logic signed [LEN-1:0] MAX_POS = {1'b0, {(LEN-1){1'b1}}};
  localparam logic signed [LEN-1:0] MAX_NEG = {1'b1, {(LEN-2){1'b0}}, 1'b1};

  // Magnitude kept one bit wider so that -2^(LEN-1) stays exact.
  function automatic logic [LEN:0] f_abs(input logic signed [LEN-1:0] v);
    logic [LEN:0] ext;
    ext = {v[LEN-1], v};
    return v[LEN-1] ? (~ext + 1'b1) : ext;
  endfunction

  function automatic logic signed [LEN-1:0] f_sat_sign(input logic neg, input logic ovf,
                                                       input logic [LEN-1:0] q);
    if (ovf) return neg ? MAX_NEG : MAX_POS;
    return neg ? signed'(~q + 1'b1) : signed'(q);
  endfunction

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_sign;
  logic                r_sat_l;
  logic [LEN-1:0]      r_div;
  logic [LEN+1:0]      r_rem;
  logic [LEN-1:0]      r_q;
  logic signed [LEN-1:0] r_tanh;
  logic                r_sat;

  logic                w_accept;
  logic [LEN:0]        w_mag;
  logic [LEN+1:0]      w_rem_sh;
  logic                w_qbit;
  logic [LEN+1:0]      w_rem_nx;
  logic [LEN-1:0]      w_q_nx;

  assign w_accept  = in_valid && in_ready;
  assign w_mag     = f_abs(sinh);
  assign w_rem_sh  = {r_rem[LEN:0], 1'b0};
  assign w_qbit    = (w_rem_sh >= {2'b00, r_div});
  assign w_rem_nx  = w_qbit ? (w_rem_sh - {2'b00, r_div}) : w_rem_sh;
  assign w_q_nx    = {r_q[LEN-2:0], w_qbit};

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign tanh      = r_tanh;
  assign sat       = r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_sat_l <= 1'b0;
      r_tanh  <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_DIV;
          r_cnt   <= CW'(OUT_FRAC);
          r_sign  <= sinh[LEN-1];
          r_sat_l <= (cosh == '0) || (w_mag >= {1'b0, cosh});
        end
        S_DIV: begin
          r_cnt <= r_cnt - 1'b1;
          // Last iteration: the final quotient bit is folded in directly.
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_tanh  <= f_sat_sign(r_sign, r_sat_l, w_q_nx);
            r_sat   <= r_sat_l;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Divider datapath, no reset needed: always reloaded on accept.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_div <= cosh;
      r_rem <= {1'b0, w_mag};
      r_q   <= '0;
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nx;
      r_q   <= w_q_nx;
    end
  end

endmodule

// File: tb/tb_cordic_tanh_divider.sv
// Directed bench for cordic_tanh_divider: latency, arithmetic, saturation,
// back-pressure and mid-division reset.
module tb_cordic_tanh_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sinh;
  logic [15:0] cosh;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] tanh;
  logic        sat;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_tanh_divider #(.LEN(16), .OUT_FRAC(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sinh(sinh), .cosh(cosh), .out_valid(out_valid), .out_ready(out_ready),
    .tanh(tanh), .sat(sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair for one edge, then scramble the inputs to prove they are not re-sampled.
  task automatic accept(input logic [15:0] s, input logic [15:0] c);
    in_valid = 1'b1;
    sinh = s;
    cosh = c;
    chk("in_ready_before_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    sinh = 16'h7FFF;
    cosh = 16'h0001;
  endtask

  task automatic wait_result(input string tag, input logic [15:0] et, input logic es);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 15);
    chk({tag, "_tanh"}, tanh, et);
    chk({tag, "_sat"}, sat, es);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic txn(input string tag, input logic [15:0] s, input logic [15:0] c,
                     input logic [15:0] et, input logic es);
    accept(s, c);
    wait_result(tag, et, es);
    handshake(tag);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sinh = '0;
    cosh = '0;
    step();
    step();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_tanh", tanh, 16'h0000);
    chk("reset_sat", sat, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);

    txn("half", 16'h2000, 16'h4000, 16'h4000, 1'b0);
    txn("neg_half", 16'hE000, 16'h4000, 16'hC000, 1'b0);
    txn("angle1", 16'h4B36, 16'h62C2, 16'h617B, 1'b0);
    txn("sat_eq", 16'h4000, 16'h4000, 16'h7FFF, 1'b1);
    txn("sat_div0", 16'h8000, 16'h0000, 16'h8001, 1'b1);

    // Back-pressure: result must hold while a new pair waits on in_valid.
    accept(16'hE000, 16'h4000);
    wait_result("bp", 16'hC000, 1'b0);
    in_valid = 1'b1;
    sinh = 16'h2000;
    cosh = 16'h4000;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_tanh", tanh, 16'hC000);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    handshake("bp");
    accept(16'h2000, 16'h4000);
    wait_result("bp_next", 16'h4000, 1'b0);
    handshake("bp_next");

    // Reset during DIV discards the operation.
    accept(16'h4B36, 16'h62C2);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_tanh", tanh, 16'h0000);
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst_no_result", out_valid, 1'b0);
    end
    txn("zero", 16'h0000, 16'h4000, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
